lcd_text_buffer: RTL and testbench
==================================

# lcd_text_buffer

Screen-image buffer and refresh sequencer for the 2x16 HD44780 character LCD. The host writes characters into a 32-cell frame buffer at any time. The block tracks which cells changed and feeds them one at a time, as a DDRAM address plus character code, to the downstream single-character LCD writer stage. Transfers are spaced so that the writer and the LCD have time to finish each one.

## Interface
- STEP_CYCLES, 100000: minimum clk cycles from one accepted transfer to the next scan (2 ms at 50 MHz); legal range 1..2^20.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe, one cell per cycle
- wr_addr  in  5  cell index; 0-15 = line 1, 16-31 = line 2
- wr_data  in  8  character code
- out_valid  out  1  transfer offered to writer
- out_dir  out  7  HD44780 DDRAM address of the cell
- out_char  out  8  character for that cell
- out_ready  in  1  writer accepts the transfer
- busy  out  1  high while any cell is dirty or a transfer/hold is in progress

## Operation
- Storage: buf[0..31] (8 bits each), dirty[0..31], scan pointer ptr (5 bits, wraps 31->0).
- Address map: out_dir = {idx[4], 2'b00, idx[3:0]}, so idx 0-15 maps to 0x00-0x0F and idx 16-31 maps to 0x40-0x4F.
- Host write: when wr_en=1, buf[wr_addr] <= wr_data and dirty[wr_addr] <= 1 on that edge, in every state. Writes are never dropped.
- FSM states: SCAN, ISSUE, HOLD.
  - SCAN: one cell is examined per cycle.
    - If dirty[ptr]=1: latch out_dir from ptr and out_char from buf[ptr], clear dirty[ptr], set out_valid <= 1, go to ISSUE.
    - Otherwise: ptr <= ptr+1 and stay in SCAN.
  - ISSUE: out_valid, out_dir and out_char are held stable until a cycle with out_ready=1.
    - On that edge: out_valid <= 0, load the counter with STEP_CYCLES-1, go to HOLD.
  - HOLD: the counter decrements each cycle.
    - On the edge where it is 0: ptr <= ptr+1, go to SCAN.
- Simultaneous write and latch on the same cell: the write wins. dirty stays 1, and buf takes the new data. The value already latched is still sent, and the cell is re-sent with the new data on a later scan.
- Repeated writes to a cell before it is latched produce a single transfer carrying the last value.
- busy = (|dirty) | (state != SCAN), combinational.

## Timing
- Reset values (edge with rst=1):
  - buf[*]=0x20 (space) and dirty[*]=1, so the full screen is refreshed after reset.
  - ptr=0, state=SCAN, out_valid=0, out_dir=0x00, out_char=0x00, counter=0, busy=1.
- Reset has priority over wr_en and over any state. Asserting rst mid-transfer drops out_valid on that edge, without waiting for out_ready.
- Latency:
  - From the first edge with rst=0 to out_valid=1 is 1 cycle (cell 0 is dirty).
  - From a write to an idle, clean buffer to out_valid is at most 33 cycles: 1 write edge plus up to 32 scan cycles.
- Handshake: a transfer completes on the edge where out_valid=1 and out_ready=1. While out_valid=1, out_dir and out_char must not change. out_ready is ignored while out_valid=0.
- Spacing: at least STEP_CYCLES+1 cycles separate consecutive transfer acceptances, plus scan cycles.
- Ordering: round-robin from the cell after the last one sent. No cell waits more than 32 transfers once it is dirty.
- Idle: out_valid=0 and busy=0 once every dirty bit is clear and the state is SCAN.

## Test plan
All scenarios run with STEP_CYCLES=4.
- Reset refresh: pulse rst, hold out_ready=1.
  - Expect 32 transfers in order: out_dir 0x00..0x0F then 0x40..0x4F, every out_char=0x20.
  - Expect at least 5 cycles between acceptances.
  - Expect busy=0 after the last HOLD.
- Single write: after idle, write 0x41 to addr 17 -> exactly one transfer with out_dir=0x41, out_char=0x41; then busy=0.
- Backpressure: write 0x5A to addr 3, hold out_ready=0 for 10 cycles after out_valid rises.
  - out_valid, out_dir=0x03 and out_char=0x5A stay stable throughout.
  - The transfer is accepted once, on the first out_ready=1.
- Collision: write 0x42 to addr 5 on the exact SCAN edge that latches cell 5, whose old value was 0x41.
  - The first transfer is 0x05/0x41.
  - A second transfer 0x05/0x42 follows.
- Coalescing: write 0x31 then 0x32 to addr 20 on consecutive cycles while the block is in HOLD for another cell -> exactly one transfer for addr 20: 0x44/0x32.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0.
  - out_valid=0 on the next edge.
  - After release, the full 32-cell space refresh restarts from out_dir=0x00.

Source files
------------

// File: rtl/lcd_text_buffer.sv
// Frame buffer for a 2x16 HD44780 display: tracks changed cells and hands them,
// one at a time and paced by a hold interval, to the single-character writer.
module lcd_text_buffer #(
    parameter int STEP_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       out_valid,
    output logic [6:0] out_dir,
    output logic [7:0] out_char,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {SCAN, ISSUE, HOLD} state_t;

    localparam logic [19:0] HOLD_LOAD = 20'(STEP_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [4:0]  ptr_reg, ptr_next;
    logic [19:0] cnt_reg, cnt_next;
    logic        out_valid_next;
    logic [6:0]  out_dir_next;
    logic [7:0]  out_char_next;
    logic        latch;

    logic [7:0]  cell_chars [32];
    logic [31:0] dirty_bits;

    // Per-cell storage. A host write on the latch edge sets dirty again, so the
    // new character is re-sent after the old one already captured for output.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_cell
            localparam logic [4:0] IDX = 5'(gi);
            logic [7:0] char_reg;
            logic       dirty_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    char_reg  <= 8'h20;
                    dirty_reg <= 1'b1;
                end else if (wr_en && wr_addr == IDX) begin
                    char_reg  <= wr_data;
                    dirty_reg <= 1'b1;
                end else if (latch && ptr_reg == IDX) begin
                    dirty_reg <= 1'b0;
                end
            end

            assign cell_chars[gi] = char_reg;
            assign dirty_bits[gi] = dirty_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SCAN;
            ptr_reg   <= 5'd0;
            cnt_reg   <= 20'd0;
            out_valid <= 1'b0;
            out_dir   <= 7'h00;
            out_char  <= 8'h00;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            out_valid <= out_valid_next;
            out_dir   <= out_dir_next;
            out_char  <= out_char_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid;
        out_dir_next   = out_dir;
        out_char_next  = out_char;
        latch          = 1'b0;
        case (state_reg)
            SCAN: begin
                if (dirty_bits[ptr_reg]) begin
                    latch          = 1'b1;
                    out_dir_next   = {ptr_reg[4], 2'b00, ptr_reg[3:0]};
                    out_char_next  = cell_chars[ptr_reg];
                    out_valid_next = 1'b1;
                    state_next     = ISSUE;
                end else begin
                    ptr_next = ptr_reg + 5'd1;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    cnt_next       = HOLD_LOAD;
                    state_next     = HOLD;
                end
            end
            HOLD: begin
                // Pointer advances only after the hold, so scanning resumes at the next cell.
                if (cnt_reg == 20'd0) begin
                    ptr_next   = ptr_reg + 5'd1;
                    state_next = SCAN;
                end else begin
                    cnt_next = cnt_reg - 20'd1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    assign busy = (|dirty_bits) | (state_reg != SCAN);

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Scoreboard bench for lcd_text_buffer: stimulus pushes expected transfers,
// a negedge monitor matches accepted transfers and tracks the LCD image.
module tb_lcd_text_buffer;

    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [6:0] out_dir;
    logic [7:0] out_char;
    logic       busy;

    always #5 clk = ~clk;

    lcd_text_buffer #(.STEP_CYCLES(STEP)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_dir(out_dir), .out_char(out_char),
        .out_ready(out_ready), .busy(busy)
    );

    typedef struct {
        logic [6:0] dir;
        logic [7:0] ch;
    } xfer_t;

    int         tests_run = 0;
    int         tests_failed = 0;
    xfer_t      exp_q[$];
    bit         ordered = 1'b0;
    bit         rand_ready = 1'b0;
    logic [7:0] host_img [32];
    logic [7:0] lcd_img [32];

    task automatic chk(string name, int act, int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dir_of(int idx);
        return (idx < 16) ? 7'(idx) : 7'(64 + idx - 16);
    endfunction

    function automatic int idx_of(logic [6:0] dir);
        return (dir >= 7'h40) ? int'(dir) - 64 + 16 : int'(dir);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic expect_xfer(int idx, logic [7:0] ch);
        xfer_t x;
        x.dir = dir_of(idx);
        x.ch  = ch;
        exp_q.push_back(x);
    endtask

    task automatic host_write(int idx, logic [7:0] ch);
        wr_en   = 1'b1;
        wr_addr = 5'(idx);
        wr_data = ch;
        host_img[idx] = ch;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while ((busy || out_valid) && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_idle_busy"}, int'(busy), 0);
        chk({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid(string name, output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, int'(out_valid), 1);
    endtask

    task automatic check_image(string name);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_cell%0d", name, i), int'(lcd_img[i]), int'(host_img[i]));
    endtask

    // Monitor: every sample where out_valid && out_ready is an acceptance on the next edge.
    int         cyc = 0;
    int         last_acc = -1;
    bit         pending = 1'b0;
    logic [6:0] held_dir;
    logic [7:0] held_char;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pending  = 1'b0;
            last_acc = -1;
        end else if (out_valid) begin
            if (pending) begin
                chk("stable_dir", int'(out_dir), int'(held_dir));
                chk("stable_char", int'(out_char), int'(held_char));
            end
            held_dir  = out_dir;
            held_char = out_char;
            if (out_ready) begin
                pending = 1'b0;
                if (last_acc >= 0) chk("spacing_ok", int'(cyc - last_acc >= STEP + 1), 1);
                last_acc = cyc;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_xfer: got dir 0x%0h char 0x%0h, expected no transfer",
                             out_dir, out_char);
                end else begin
                    int k;
                    k = 0;
                    if (!ordered)
                        for (int i = exp_q.size() - 1; i >= 0; i--)
                            if (exp_q[i].dir == out_dir) k = i;
                    chk("xfer_dir", int'(out_dir), int'(exp_q[k].dir));
                    chk("xfer_char", int'(out_char), int'(exp_q[k].ch));
                    exp_q.delete(k);
                end
                lcd_img[idx_of(out_dir)] = out_char;
            end else begin
                pending = 1'b1;
            end
        end else begin
            pending = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit used [32];
        for (int i = 0; i < 32; i++) begin
            host_img[i] = 8'h20;
            lcd_img[i]  = 8'h00;
        end

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_dir", int'(out_dir), 0);
        chk("reset_char", int'(out_char), 0);
        chk("reset_busy", int'(busy), 1);

        // Full refresh after reset, strictly in address order
        ordered = 1'b1;
        for (int i = 0; i < 32; i++) expect_xfer(i, 8'h20);
        out_ready = 1'b1;
        rst = 1'b0;
        tick();
        chk("first_latency_valid", int'(out_valid), 1);
        wait_idle("refresh");
        check_image("refresh_img");
        ordered = 1'b0;

        // Single write
        expect_xfer(17, 8'h41);
        host_write(17, 8'h41);
        wait_valid("single", n);
        chk("single_latency_ok", int'(n + 1 <= 33), 1);
        wait_idle("single");

        // Backpressure
        out_ready = 1'b0;
        expect_xfer(3, 8'h5A);
        host_write(3, 8'h5A);
        wait_valid("bp", n);
        repeat (10) begin
            tick();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_dir", int'(out_dir), 'h03);
            chk("bp_char", int'(out_char), 'h5A);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_accepted", int'(out_valid), 0);
        wait_idle("bp");

        // Collision: write lands on the edge that latches cell 5
        out_ready = 1'b0;
        expect_xfer(4, 8'h11);
        host_write(4, 8'h11);
        wait_valid("coll_pre", n);
        expect_xfer(5, 8'h41);
        expect_xfer(5, 8'h42);
        host_write(5, 8'h41);
        out_ready = 1'b1;
        tick();
        repeat (STEP) tick();
        host_write(5, 8'h42);
        chk("coll_latch_valid", int'(out_valid), 1);
        chk("coll_latch_dir", int'(out_dir), 'h05);
        chk("coll_latch_char", int'(out_char), 'h41);
        wait_idle("coll");

        // Coalescing: two writes to cell 20 during HOLD of cell 2
        expect_xfer(2, 8'h55);
        expect_xfer(20, 8'h32);
        host_write(2, 8'h55);
        wait_valid("coal", n);
        tick();
        host_write(20, 8'h31);
        host_write(20, 8'h32);
        wait_idle("coal");

        // Randomized batches of distinct-cell writes with random backpressure
        rand_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            int cnt;
            for (int i = 0; i < 32; i++) used[i] = 1'b0;
            cnt = $urandom_range(1, 6);
            for (int w = 0; w < cnt; w++) begin
                int idx;
                logic [7:0] ch;
                do idx = $urandom_range(0, 31); while (used[idx]);
                used[idx] = 1'b1;
                ch = 8'($urandom_range(0, 255));
                expect_xfer(idx, ch);
                host_write(idx, ch);
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_idle($sformatf("rand%0d", b));
        end
        rand_ready = 1'b0;
        check_image("rand_img");

        // Reset mid-transfer
        out_ready = 1'b0;
        expect_xfer(9, 8'h77);
        host_write(9, 8'h77);
        wait_valid("mid", n);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 1);
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            host_img[i] = 8'h20;
            expect_xfer(i, 8'h20);
        end
        ordered = 1'b1;
        out_ready = 1'b1;
        rst = 1'b0;
        tick();
        chk("mid_restart_valid", int'(out_valid), 1);
        chk("mid_restart_dir", int'(out_dir), 'h00);
        wait_idle("mid");
        check_image("mid_img");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
